// File: rtl/crabcore_pkg.sv
// Shared constants and types for the crabcore RV32I multi-cycle core.
package crabcore_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IO_BYTE = 3'd0;
  localparam logic [2:0] IO_HALF = 3'd1;
  localparam logic [2:0] IO_WORD = 3'd2;

  typedef enum logic [4:0] {
    ST_FETCH      = 5'd0,
    ST_FETCH_WAIT = 5'd1,
    ST_EXECUTE    = 5'd2,
    ST_MEM        = 5'd3,
    ST_MEM_WAIT   = 5'd4,
    ST_WRITEBACK  = 5'd5
  } core_state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // SUB only exists for register-register ops; bit 30 of an I-immediate is just data.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                         input logic funct7_5,
                                         input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'd0:    op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/crabcore_alu.sv
// Combinational ALU plus branch comparator for crabcore.
module crabcore_alu
  import crabcore_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  br_funct3,
  output logic [31:0] result,
  output logic        br_taken
);

  logic eq, lt, ltu;

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, lt};
      ALU_SLTU: result = {31'd0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = 32'd0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (br_funct3)
      3'd0:    br_taken = eq;
      3'd1:    br_taken = !eq;
      3'd4:    br_taken = lt;
      3'd5:    br_taken = !lt;
      3'd6:    br_taken = ltu;
      3'd7:    br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/crabcore.sv
// crabcore: multi-cycle RV32I core with a toggle-acknowledged memory port.
// Define CRABCORE_DEBUG_EN to drive live values on the debug ports (zero otherwise).
module crabcore
  import crabcore_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_addr_valid,
  output logic [31:0]       mem_addr,
  output logic              mem_data_valid,
  output logic [31:0]       mem_data,
  output logic [2:0]        io_mode,
  input  logic              mem_ready,
  input  logic [31:0]       mem_input,
  input  logic              mem_write_done,
  output logic              mem_ack,
  output logic [31:0][31:0] registers_debug,
  output logic [31:0]       pc_debug,
  output logic [4:0]        core_state_debug
);

  core_state_e       state_q, state_d;
  logic [31:0]       pc_q, pc_d, instr_q, instr_d;
  logic [31:0]       result_q, result_d, next_pc_q, next_pc_d;
  logic              rd_we_q, rd_we_d;
  logic [31:0][31:0] regs_q, regs_d;
  logic              mem_addr_valid_q, mem_addr_valid_d;
  logic              mem_data_valid_q, mem_data_valid_d;
  logic              mem_ack_q, mem_ack_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [2:0]        io_mode_q, io_mode_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, ls_addr, pc_plus4, pc_target;
  logic [31:0] store_data, load_lane, load_val;
  logic [2:0]  access_mode;
  logic        is_store;
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_result;
  logic        br_taken;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'd0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // x0 is never written, so a plain read already returns zero for it.
  assign rs1_val  = regs_q[rs1];
  assign rs2_val  = regs_q[rs2];
  assign is_store = (opcode == OPC_STORE);
  assign ls_addr  = rs1_val + (is_store ? imm_s : imm_i);
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_target = pc_q + ((opcode == OPC_JAL)    ? imm_j :
                             (opcode == OPC_BRANCH) ? imm_b : imm_u);

  assign alu_op      = alu_decode(funct3, instr_q[30], opcode == OPC_OP);
  assign alu_b       = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_val : imm_i;
  assign access_mode = funct3[1] ? IO_WORD : {2'b00, funct3[0]};

  crabcore_alu u_alu (
    .op        (alu_op),
    .a         (rs1_val),
    .b         (alu_b),
    .br_funct3 (funct3),
    .result    (alu_result),
    .br_taken  (br_taken)
  );

  always_comb begin
    store_data = rs2_val;
    case (funct3[1:0])
      2'd0:    store_data = {24'd0, rs2_val[7:0]};
      2'd1:    store_data = {16'd0, rs2_val[15:0]};
      default: store_data = rs2_val;
    endcase
  end

  // The addressed byte/half is shifted down to bit 0 before extension.
  always_comb begin
    load_lane = mem_input >> {mem_addr_q[1:0], 3'b000};
    load_val  = mem_input;
    case (funct3)
      3'd0:    load_val = {{24{load_lane[7]}}, load_lane[7:0]};
      3'd1:    load_val = {{16{load_lane[15]}}, load_lane[15:0]};
      3'd4:    load_val = {24'd0, load_lane[7:0]};
      3'd5:    load_val = {16'd0, load_lane[15:0]};
      default: load_val = mem_input;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    instr_d          = instr_q;
    result_d         = result_q;
    next_pc_d        = next_pc_q;
    rd_we_d          = rd_we_q;
    regs_d           = regs_q;
    mem_addr_valid_d = mem_addr_valid_q;
    mem_data_valid_d = mem_data_valid_q;
    mem_addr_d       = mem_addr_q;
    mem_data_d       = mem_data_q;
    io_mode_d        = io_mode_q;
    mem_ack_d        = mem_ack_q;

    case (state_q)
      ST_FETCH: begin
        if (!mem_ready) begin
          mem_addr_d       = pc_q;
          io_mode_d        = IO_WORD;
          mem_addr_valid_d = 1'b1;
          mem_data_valid_d = 1'b0;
          state_d          = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        if (mem_ready) begin
          instr_d          = mem_input;
          mem_ack_d        = ~mem_ack_q;
          mem_addr_valid_d = 1'b0;
          state_d          = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        next_pc_d = pc_plus4;
        result_d  = alu_result;
        rd_we_d   = 1'b0;
        state_d   = ST_WRITEBACK;
        case (opcode)
          OPC_LUI:   begin result_d = imm_u;     rd_we_d = 1'b1; end
          OPC_AUIPC: begin result_d = pc_target; rd_we_d = 1'b1; end
          OPC_JAL: begin
            result_d  = pc_plus4;
            next_pc_d = pc_target;
            rd_we_d   = 1'b1;
          end
          OPC_JALR: begin
            result_d  = pc_plus4;
            next_pc_d = {ls_addr[31:1], 1'b0};
            rd_we_d   = 1'b1;
          end
          OPC_BRANCH: if (br_taken) next_pc_d = pc_target;
          OPC_OPIMM, OPC_OP: rd_we_d = 1'b1;
          OPC_LOAD: begin
            rd_we_d    = 1'b1;
            mem_addr_d = ls_addr;
            io_mode_d  = access_mode;
            state_d    = ST_MEM;
          end
          OPC_STORE: begin
            mem_addr_d = ls_addr;
            mem_data_d = store_data;
            io_mode_d  = access_mode;
            state_d    = ST_MEM;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (is_store) begin
          mem_addr_valid_d = 1'b1;
          mem_data_valid_d = 1'b1;
          state_d          = ST_MEM_WAIT;
        end else if (!mem_ready) begin
          mem_addr_valid_d = 1'b1;
          state_d          = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (is_store) begin
          if (mem_write_done) begin
            mem_addr_valid_d = 1'b0;
            mem_data_valid_d = 1'b0;
            state_d          = ST_WRITEBACK;
          end
        end else if (mem_ready) begin
          mem_ack_d        = ~mem_ack_q;
          mem_addr_valid_d = 1'b0;
          result_d         = load_val;
          state_d          = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        if (rd_we_q && (rd != 5'd0)) regs_d[rd] = result_q;
        pc_d    = next_pc_q;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_FETCH;
      pc_q             <= RESET_PC;
      instr_q          <= 32'd0;
      result_q         <= 32'd0;
      next_pc_q        <= RESET_PC;
      rd_we_q          <= 1'b0;
      regs_q           <= '0;
      mem_addr_valid_q <= 1'b0;
      mem_data_valid_q <= 1'b0;
      mem_addr_q       <= 32'd0;
      mem_data_q       <= 32'd0;
      io_mode_q        <= IO_WORD;
      mem_ack_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      instr_q          <= instr_d;
      result_q         <= result_d;
      next_pc_q        <= next_pc_d;
      rd_we_q          <= rd_we_d;
      regs_q           <= regs_d;
      mem_addr_valid_q <= mem_addr_valid_d;
      mem_data_valid_q <= mem_data_valid_d;
      mem_addr_q       <= mem_addr_d;
      mem_data_q       <= mem_data_d;
      io_mode_q        <= io_mode_d;
      mem_ack_q        <= mem_ack_d;
    end
  end

  assign mem_addr_valid = mem_addr_valid_q;
  assign mem_data_valid = mem_data_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data       = mem_data_q;
  assign io_mode        = io_mode_q;
  assign mem_ack        = mem_ack_q;

`ifdef CRABCORE_DEBUG_EN
  assign registers_debug  = regs_q;
  assign pc_debug         = pc_q;
  assign core_state_debug = state_q;
`else
  assign registers_debug  = '0;
  assign pc_debug         = 32'd0;
  assign core_state_debug = 5'd0;
`endif

endmodule

// File: tb/tb_crabcore.sv
// Directed bench for crabcore: runs a small program against a toggle-ack memory model
// and checks bus traffic, stored results, debug ports and asynchronous reset.
module tb_crabcore;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_addr_valid, mem_data_valid, mem_ack;
  logic [31:0]       mem_addr, mem_data;
  logic [2:0]        io_mode;
  logic              mem_ready = 1'b0;
  logic [31:0]       mem_input = 32'd0;
  logic              mem_write_done = 1'b0;
  logic [31:0][31:0] registers_debug;
  logic [31:0]       pc_debug;
  logic [4:0]        core_state_debug;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic [34:0] rd_log [$];
  logic [66:0] wr_log [$];
  int          reads_answered = 0;
  int          ack_toggles = 0;
  int          ack_base = 0;
  logic        ack_seen = 1'b0;
  logic        hold_off = 1'b0;

  crabcore #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_addr_valid   (mem_addr_valid),
    .mem_addr         (mem_addr),
    .mem_data_valid   (mem_data_valid),
    .mem_data         (mem_data),
    .io_mode          (io_mode),
    .mem_ready        (mem_ready),
    .mem_input        (mem_input),
    .mem_write_done   (mem_write_done),
    .mem_ack          (mem_ack),
    .registers_debug  (registers_debug),
    .pc_debug         (pc_debug),
    .core_state_debug (core_state_debug)
  );

  always #5 clk = ~clk;

  always @(mem_ack) ack_toggles++;

  // RV32I encoders so the program table below reads like assembly.
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [11:0] i = imm[11:0];
    return {i, rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [11:0] i = imm[11:0];
    return {i[11:5], rs2[4:0], rs1[4:0], f3[2:0], i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] i = imm[12:0];
    return {i[12], i[10:5], rs2[4:0], rs1[4:0], f3[2:0], i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Memory model: answers one read or write at a time, drops mem_ready only
  // once the core has toggled mem_ack.
  task automatic memResponder();
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready      = 1'b0;
        mem_write_done = 1'b0;
        ack_seen       = 1'b0;
      end else begin
        if (mem_ready && (mem_ack !== ack_seen)) begin
          mem_ready = 1'b0;
          ack_seen  = mem_ack;
        end
        if (mem_addr_valid && mem_data_valid && !mem_write_done) begin
          case (io_mode)
            3'd0: mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] = mem_data[7:0];
            3'd1: mem[mem_addr[7:2]][16*mem_addr[1] +: 16] = mem_data[15:0];
            default: mem[mem_addr[7:2]] = mem_data;
          endcase
          wr_log.push_back({io_mode, mem_addr, mem_data});
          mem_write_done = 1'b1;
        end else if (!mem_addr_valid) begin
          mem_write_done = 1'b0;
        end
        if (mem_addr_valid && !mem_data_valid && !mem_ready && !hold_off) begin
          mem_input = mem[mem_addr[7:2]];
          mem_ready = 1'b1;
          rd_log.push_back({io_mode, mem_addr});
          reads_answered++;
        end
      end
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = enc_i(5, 0, 0, 1, 7'h13);     // 00 ADDI x1,x0,5
    mem[1]  = enc_s(128, 1, 0, 2);          // 04 SW x1,128(x0)
    mem[2]  = enc_i(3, 0, 0, 1, 7'h13);     // 08 ADDI x1,x0,3
    mem[3]  = enc_b(8, 1, 1, 0);            // 0C BEQ x1,x1,+8
    mem[4]  = enc_i(9, 0, 0, 7, 7'h13);     // 10 ADDI x7,x0,9 (skipped)
    mem[5]  = enc_i(7, 0, 0, 0, 7'h13);     // 14 ADDI x0,x0,7
    mem[6]  = enc_s(136, 0, 0, 2);          // 18 SW x0,136(x0)
    mem[7]  = enc_s(140, 7, 0, 2);          // 1C SW x7,140(x0)
    mem[8]  = enc_j(16, 5);                 // 20 JAL x5,+16
    mem[9]  = enc_i(1, 0, 0, 8, 7'h13);     // 24..2C skipped
    mem[10] = enc_i(1, 0, 0, 8, 7'h13);
    mem[11] = enc_i(1, 0, 0, 8, 7'h13);
    mem[12] = enc_s(144, 5, 0, 2);          // 30 SW x5,144(x0)
    mem[13] = enc_i(-1, 0, 0, 1, 7'h13);    // 34 ADDI x1,x0,-1
    mem[14] = enc_s(64, 1, 0, 2);           // 38 SW x1,64(x0)
    mem[15] = enc_j(8, 0);                  // 3C JAL x0,+8 (over data word 0x40)
    mem[17] = enc_i(64, 0, 2, 2, 7'h03);    // 44 LW x2,64(x0)
    mem[18] = enc_s(148, 2, 0, 2);          // 48 SW x2,148(x0)
    mem[19] = enc_i(128, 0, 0, 9, 7'h13);   // 4C ADDI x9,x0,128
    mem[20] = enc_s(64, 9, 0, 2);           // 50 SW x9,64(x0)
    mem[21] = enc_i(64, 0, 0, 3, 7'h03);    // 54 LB x3,64(x0)
    mem[22] = enc_i(64, 0, 4, 4, 7'h03);    // 58 LBU x4,64(x0)
    mem[23] = enc_s(152, 3, 0, 2);          // 5C SW x3,152(x0)
    mem[24] = enc_s(156, 4, 0, 2);          // 60 SW x4,156(x0)
    mem[25] = enc_j(0, 0);                  // 64 JAL x0,0 (park)
    mem[34] = 32'hDEAD_BEEF;
    mem[35] = 32'h1234_5678;
  endtask

  logic [31:0] exp_rd_addr [23] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14, 32'h18, 32'h1C, 32'h20,
                                    32'h30, 32'h34, 32'h38, 32'h3C, 32'h44, 32'h40, 32'h48, 32'h4C,
                                    32'h50, 32'h54, 32'h40, 32'h58, 32'h40, 32'h5C, 32'h60};
  logic [31:0] exp_wr_addr [9] = '{32'h80, 32'h88, 32'h8C, 32'h90, 32'h40, 32'h94, 32'h40, 32'h98, 32'h9C};
  logic [31:0] exp_wr_data [9] = '{32'h5, 32'h0, 32'h0, 32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h80, 32'hFFFF_FF80, 32'h80};

  initial begin
    logic [34:0] rd_entry;
    logic [66:0] wr_entry;
    logic [2:0]  exp_mode;
    bit          done;

    reset = 1'b0;
    applyStimulus();
    fork
      memResponder();
    join_none

    // Held in reset: quiet bus, word mode, PC at RESET_PC.
    @(negedge clk);
    checkOutput("rst_addr_valid", 64'(mem_addr_valid), 64'd0);
    checkOutput("rst_data_valid", 64'(mem_data_valid), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_data", 64'(mem_data), 64'd0);
    checkOutput("rst_io_mode", 64'(io_mode), 64'd2);
    checkOutput("rst_mem_ack", 64'(mem_ack), 64'd0);
    checkOutput("rst_pc", 64'(pc_debug), 64'd0);
    checkOutput("rst_state", 64'(core_state_debug), 64'd0);
    ack_base = ack_toggles;
    reset = 1'b1;

`ifdef CRABCORE_DEBUG_EN
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (pc_debug == 32'd4) done = 1'b1;
    end
    checkOutput("first_wb_seen", 64'(done), 64'd1);
    checkOutput("first_wb_x1", 64'(registers_debug[1]), 64'd5);
`else
    repeat (20) @(negedge clk);
    checkOutput("dbg_regs_zero", 64'(registers_debug[1] | registers_debug[5]), 64'd0);
    checkOutput("dbg_pc_zero", 64'(pc_debug), 64'd0);
    checkOutput("dbg_state_zero", 64'(core_state_debug), 64'd0);
`endif

    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (wr_log.size() >= 9) done = 1'b1;
    end
    checkOutput("all_stores_seen", 64'(done), 64'd1);

    for (int i = 0; i < 9; i++) begin
      wr_entry = (i < wr_log.size()) ? wr_log[i] : 'x;
      checkOutput($sformatf("wr%0d_addr", i), 64'(wr_entry[63:32]), 64'(exp_wr_addr[i]));
      checkOutput($sformatf("wr%0d_data", i), 64'(wr_entry[31:0]), 64'(exp_wr_data[i]));
      checkOutput($sformatf("wr%0d_mode", i), 64'(wr_entry[66:64]), 64'd2);
    end

    for (int i = 0; i < 23; i++) begin
      rd_entry = (i < rd_log.size()) ? rd_log[i] : 'x;
      exp_mode = (i == 18 || i == 20) ? 3'd0 : 3'd2;
      checkOutput($sformatf("rd%0d_addr", i), 64'(rd_entry[31:0]), 64'(exp_rd_addr[i]));
      checkOutput($sformatf("rd%0d_mode", i), 64'(rd_entry[34:32]), 64'(exp_mode));
    end
    checkOutput("mem_word_64", 64'(mem[16]), 64'h80);

    // Compare acknowledges with answered reads at a point where no read is pending.
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!mem_ready) done = 1'b1;
    end
    checkOutput("ack_idle_found", 64'(done), 64'd1);
    checkOutput("ack_per_read", 64'(ack_toggles - ack_base), 64'(reads_answered));

`ifdef CRABCORE_DEBUG_EN
    checkOutput("x0_zero", 64'(registers_debug[0]), 64'd0);
    checkOutput("x2_lw", 64'(registers_debug[2]), 64'hFFFF_FFFF);
    checkOutput("x3_lb", 64'(registers_debug[3]), 64'hFFFF_FF80);
    checkOutput("x4_lbu", 64'(registers_debug[4]), 64'h80);
    checkOutput("x5_jal_link", 64'(registers_debug[5]), 64'h24);
    checkOutput("x7_skipped", 64'(registers_debug[7]), 64'd0);
    checkOutput("x8_skipped", 64'(registers_debug[8]), 64'd0);
`endif

    // Stall the parked fetch, then pull reset in the middle of FETCH_WAIT.
    hold_off = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (mem_addr_valid && !mem_data_valid && !mem_ready) done = 1'b1;
    end
    checkOutput("stall_reached", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
`ifdef CRABCORE_DEBUG_EN
    checkOutput("stall_state", 64'(core_state_debug), 64'd1);
    checkOutput("stall_pc", 64'(pc_debug), 64'h64);
`endif
    checkOutput("stall_addr", 64'(mem_addr), 64'h64);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_addr_valid", 64'(mem_addr_valid), 64'd0);
    checkOutput("async_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("async_pc", 64'(pc_debug), 64'd0);
    checkOutput("async_state", 64'(core_state_debug), 64'd0);
    checkOutput("async_io_mode", 64'(io_mode), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
